// File: rtl/descrambler_deframer_pkg.sv
// Shared defaults and state type for the self-synchronising descrambler/deframer.
package descrambler_deframer_pkg;

  localparam int LFSR_LEN_DEF = 15;
  localparam int TAP_DEF      = 14;
  localparam int BYTE_W_DEF   = 8;

  typedef enum logic {
    FLUSH = 1'b0,
    RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/descrambler_deframer_bit_packer.sv
// Serial-to-word packer with a single holding register and sticky overflow.
// Bits arrive LSB first; a completed word loads the holding register only if it
// is empty or being accepted in the same cycle, otherwise the word is dropped.
module bit_packer
  import descrambler_deframer_pkg::*;
#(
  parameter int BYTE_W = BYTE_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_bit,
  input  logic              in_valid,
  input  logic              ready,
  output logic [BYTE_W-1:0] data,
  output logic              data_valid,
  output logic              overflow
);

  localparam int CW = (BYTE_W > 1) ? $clog2(BYTE_W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BYTE_W - 1);

  logic [BYTE_W-1:0] acc;
  logic [BYTE_W-1:0] word;
  logic [CW-1:0]     bit_cnt;
  logic              complete;
  logic              accept;
  logic              load;

  assign complete = in_valid & (bit_cnt == CNT_LAST);
  assign accept   = data_valid & ready;
  assign load     = complete & (~data_valid | ready);

  // Word as it stands once the incoming bit is placed at its position.
  always_comb begin
    word          = acc;
    word[bit_cnt] = in_bit;
  end

  // Accumulator and bit position; cleared on resync so partial words vanish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      bit_cnt <= '0;
    end else if (clr) begin
      acc     <= '0;
      bit_cnt <= '0;
    end else if (in_valid) begin
      acc     <= word;
      bit_cnt <= complete ? '0 : bit_cnt + 1'b1;
    end
  end

  // Holding register handshake; a held word survives resync.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data       <= '0;
      data_valid <= 1'b0;
    end else if (load) begin
      data       <= word;
      data_valid <= 1'b1;
    end else if (accept) begin
      data_valid <= 1'b0;
    end
  end

  // Sticky flag for a completed word that found the holding register busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (clr) begin
      overflow <= 1'b0;
    end else if (complete && !load) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/descrambler_deframer.sv
// Self-synchronising descrambler (1 + x^TAP + x^LFSR_LEN) with flush/run lock
// FSM and word deframing. The shift register holds received (scrambled) bits,
// so it is correct after LFSR_LEN bits regardless of the scrambler seed.
module descrambler_deframer
  import descrambler_deframer_pkg::*;
#(
  parameter int LFSR_LEN = LFSR_LEN_DEF,
  parameter int TAP      = TAP_DEF,
  parameter int BYTE_W   = BYTE_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              bit_i,
  input  logic              bit_valid_i,
  input  logic              sync_clr_i,
  output logic              bit_o,
  output logic              bit_valid_o,
  output logic [BYTE_W-1:0] data_o,
  output logic              data_valid_o,
  input  logic              data_ready_i,
  output logic              locked_o,
  output logic              overflow_o
);

  localparam int FCW = $clog2(LFSR_LEN + 1);
  localparam logic [FCW-1:0] FLUSH_LAST = FCW'(LFSR_LEN - 1);
  localparam logic [FCW-1:0] FLUSH_MAX  = FCW'(LFSR_LEN);

  state_t            state;
  state_t            state_next;
  logic [LFSR_LEN:1] sr;
  logic [FCW-1:0]    flush_cnt;
  logic              take;
  logic              run_bit;
  logic              d;

  // A bit is consumed only when valid and not overridden by a resync request.
  assign take    = bit_valid_i & ~sync_clr_i;
  assign run_bit = take & (state == RUN);
  assign d       = bit_i ^ sr[TAP] ^ sr[LFSR_LEN];

  // Lock FSM: leave FLUSH on the bit that completes the flush, drop on resync.
  always_comb begin
    state_next = state;
    case (state)
      FLUSH: begin
        if (sync_clr_i) begin
          state_next = FLUSH;
        end else if (take && (flush_cnt == FLUSH_LAST)) begin
          state_next = RUN;
        end else begin
          state_next = FLUSH;
        end
      end
      RUN: begin
        if (sync_clr_i) begin
          state_next = FLUSH;
        end else begin
          state_next = RUN;
        end
      end
      default: state_next = FLUSH;
    endcase
  end

  // State register; locked is registered from the next state so both move together.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= FLUSH;
      locked_o <= 1'b0;
    end else begin
      state    <= state_next;
      locked_o <= (state_next == RUN);
    end
  end

  // Descrambler history of received bits plus saturating flush counter.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sr        <= '0;
      flush_cnt <= '0;
    end else if (sync_clr_i) begin
      sr        <= '0;
      flush_cnt <= '0;
    end else if (bit_valid_i) begin
      sr <= {sr[LFSR_LEN-1:1], bit_i};
      if (flush_cnt != FLUSH_MAX) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

  // Registered serial output, only qualified while locked.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bit_o       <= 1'b0;
      bit_valid_o <= 1'b0;
    end else begin
      bit_valid_o <= run_bit;
      if (run_bit) begin
        bit_o <= d;
      end
    end
  end

  bit_packer #(
    .BYTE_W(BYTE_W)
  ) u_bit_packer (
    .clk       (clk_i),
    .rst_n     (rst_n_i),
    .clr       (sync_clr_i),
    .in_bit    (d),
    .in_valid  (run_bit),
    .ready     (data_ready_i),
    .data      (data_o),
    .data_valid(data_valid_o),
    .overflow  (overflow_o)
  );

endmodule

// File: tb/tb_descrambler_deframer.sv
// Bench: a reference scrambler feeds plaintext; the expected stream is the
// plaintext itself once LFSR_LEN bits have been received since the last flush.
module tb_descrambler_deframer;

  logic       clk;
  logic       rst_n_i;
  logic       bit_i;
  logic       bit_valid_i;
  logic       sync_clr_i;
  logic       bit_o;
  logic       bit_valid_o;
  logic [7:0] data_o;
  logic       data_valid_o;
  logic       data_ready_i;
  logic       locked_o;
  logic       overflow_o;

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic [15:1] scr;
  int          m_flush;
  logic        m_bit;
  logic        m_bv;
  logic [7:0]  m_acc;
  int          m_pcnt;
  logic [7:0]  m_data;
  logic        m_dv;
  logic        m_ovf;

  descrambler_deframer dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n_i),
    .bit_i       (bit_i),
    .bit_valid_i (bit_valid_i),
    .sync_clr_i  (sync_clr_i),
    .bit_o       (bit_o),
    .bit_valid_o (bit_valid_o),
    .data_o      (data_o),
    .data_valid_o(data_valid_o),
    .data_ready_i(data_ready_i),
    .locked_o    (locked_o),
    .overflow_o  (overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("locked", {7'd0, locked_o}, {7'd0, (m_flush >= 15)});
    chk("bit_valid", {7'd0, bit_valid_o}, {7'd0, m_bv});
    chk("bit", {7'd0, bit_o}, {7'd0, m_bit});
    chk("data_valid", {7'd0, data_valid_o}, {7'd0, m_dv});
    chk("data", data_o, m_data);
    chk("overflow", {7'd0, overflow_o}, {7'd0, m_ovf});
  endtask

  // One clock: scramble plaintext p, drive, then advance the model and compare.
  task automatic step(input logic p, input logic v, input logic c, input logic r);
    logic s;
    logic was_locked;
    logic accept;
    logic loaded;
    s            = p ^ scr[14] ^ scr[15];
    bit_i        = v ? s : 1'($urandom_range(0, 1));
    bit_valid_i  = v;
    sync_clr_i   = c;
    data_ready_i = r;
    was_locked   = (m_flush >= 15);
    if (v) scr = {scr[14:1], s};
    @(posedge clk);
    #1;
    accept = m_dv && r;
    loaded = 1'b0;
    m_bv   = 1'b0;
    if (c) begin
      m_flush = 0;
      m_pcnt  = 0;
      m_ovf   = 1'b0;
    end else if (v) begin
      if (was_locked) begin
        m_bv          = 1'b1;
        m_bit         = p;
        m_acc[m_pcnt] = p;
        m_pcnt++;
        if (m_pcnt == 8) begin
          m_pcnt = 0;
          if (!m_dv || r) begin
            m_data = m_acc;
            loaded = 1'b1;
          end else begin
            m_ovf = 1'b1;
          end
        end
      end
      if (m_flush < 15) m_flush++;
    end
    if (loaded) m_dv = 1'b1;
    else if (accept) m_dv = 1'b0;
    check_all();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic r);
    for (int i = 0; i < 8; i++) step(b[i], 1'b1, 1'b0, r);
  endtask

  task automatic send_rand(input int n, input logic r);
    for (int i = 0; i < n; i++) step(1'($urandom_range(0, 1)), 1'b1, 1'b0, r);
  endtask

  // Asynchronous reset pulse mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    bit_valid_i  = 1'b0;
    sync_clr_i   = 1'b0;
    data_ready_i = 1'b0;
    rst_n_i      = 1'b0;
    #2;
    m_flush = 0;
    m_bit   = 1'b0;
    m_bv    = 1'b0;
    m_acc   = 8'h00;
    m_pcnt  = 0;
    m_data  = 8'h00;
    m_dv    = 1'b0;
    m_ovf   = 1'b0;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst_n_i = 1'b1;
  endtask

  initial begin
    rst_n_i      = 1'b1;
    bit_i        = 1'b0;
    bit_valid_i  = 1'b0;
    sync_clr_i   = 1'b0;
    data_ready_i = 1'b0;
    scr          = 15'd0;
    #3;
    do_reset();

    // all-zero line: lock after 15 bits, then a zero word
    scr = 15'd0;
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
    chk("zero_locked", {7'd0, locked_o}, 8'd1);
    send_byte(8'h00, 1'b1);
    chk("zero_dv", {7'd0, data_valid_o}, 8'd1);
    chk("zero_data", data_o, 8'h00);

    // reference scrambler with arbitrary seed, two known bytes
    do_reset();
    scr = 15'($urandom);
    send_rand(15, 1'b1);
    send_byte(8'hA5, 1'b1);
    chk("a5_data", data_o, 8'hA5);
    send_byte(8'h3C, 1'b1);
    chk("3c_data", data_o, 8'h3C);

    // backpressure across two words: first held, second dropped
    step(1'b0, 1'b0, 1'b0, 1'b1);
    send_byte(8'h5A, 1'b0);
    send_byte(8'hC3, 1'b0);
    chk("ovf_data", data_o, 8'h5A);
    chk("ovf_flag", {7'd0, overflow_o}, 8'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // gapped valid while locked
    for (int i = 0; i < 16; i++) begin
      step(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
    end

    // resync after 4 bits of a word; clear wins over a simultaneous bit
    step(1'b0, 1'b0, 1'b0, 1'b1);
    send_rand(4, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("clr_unlocked", {7'd0, locked_o}, 8'd0);
    chk("clr_ovf", {7'd0, overflow_o}, 8'd0);
    send_rand(14, 1'b1);
    chk("clr_still_flush", {7'd0, locked_o}, 8'd0);
    send_rand(1, 1'b1);
    chk("clr_relock", {7'd0, locked_o}, 8'd1);
    send_byte(8'h96, 1'b1);
    chk("clr_word", data_o, 8'h96);

    // reset while a word is held and 5 bits are packed
    send_byte(8'h3E, 1'b0);
    send_rand(5, 1'b0);
    do_reset();
    send_rand(14, 1'b1);
    chk("rst_still_flush", {7'd0, locked_o}, 8'd0);
    send_rand(1, 1'b1);
    send_byte(8'h81, 1'b1);
    chk("rst_word", data_o, 8'h81);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 79) == 0), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
